// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dice_pkg
// Brief    : Shared FSM encoding, pip patterns and face helpers for dice_roller.
// Revision : 1.0
// ============================================================================
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TUMBLE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Pip order: [0]TL [1]TR [2]ML [3]C [4]MR [5]BL [6]BR
    localparam logic [6:0] PIPS_0 = 7'h00;
    localparam logic [6:0] PIPS_1 = 7'h08;
    localparam logic [6:0] PIPS_2 = 7'h41;
    localparam logic [6:0] PIPS_3 = 7'h49;
    localparam logic [6:0] PIPS_4 = 7'h63;
    localparam logic [6:0] PIPS_5 = 7'h6B;
    localparam logic [6:0] PIPS_6 = 7'h77;

    function automatic logic is_valid_face(input logic [2:0] v);
        return (v >= 3'd1) && (v <= 3'd6);
    endfunction

    function automatic logic [6:0] face_pips(input logic [2:0] v);
        logic [6:0] p;
        case (v)
            3'd1:    p = PIPS_1;
            3'd2:    p = PIPS_2;
            3'd3:    p = PIPS_3;
            3'd4:    p = PIPS_4;
            3'd5:    p = PIPS_5;
            3'd6:    p = PIPS_6;
            default: p = PIPS_0;
        endcase
        return p;
    endfunction

endpackage : dice_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : 2-flop synchroniser, stability counter and debounced rising-edge pulse.
// Revision : 1.0
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // The counter tracks how many consecutive samples disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
            btn_level <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= btn_level;
            if (r_sync2 == btn_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                btn_level <= r_sync2;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_rise = btn_level & ~r_level_d;

endmodule : button_debounce
`default_nettype wire

// File: rtl/dice_roller.sv
`default_nettype none
// ============================================================================
// Module   : dice_roller
// Brief    : Roll FSM: debounced press, tumbling animation, settle on a face 1..6.
// Revision : 1.0
// ============================================================================
module dice_roller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TUMBLE_CYCLES   = 16,
    parameter int TUMBLE_STEP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rand_value,
    input  logic       roll_btn,
    output logic [2:0] dice_value,
    output logic [6:0] dice_pips,
    output logic       rolling,
    output logic       done
);

    localparam int TW = $clog2(TUMBLE_CYCLES + 1);
    localparam int SW = $clog2(TUMBLE_STEP + 1);
    localparam logic [TW-1:0] c_tumble_load = TW'(TUMBLE_CYCLES - 1);
    localparam logic [SW-1:0] c_step_last   = SW'(TUMBLE_STEP - 1);

    state_t        r_state;
    logic [TW-1:0] r_tumble_cnt;
    logic [SW-1:0] r_step_cnt;
    logic          r_roll_req;
    logic          w_btn_level;
    logic          w_btn_rise;
    logic          w_face_ok;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (roll_btn),
        .btn_level (w_btn_level),
        .btn_rise  (w_btn_rise)
    );

    assign w_face_ok = is_valid_face(rand_value);

    // dice_pips is loaded alongside dice_value so the decode never lags the face.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tumble_cnt <= '0;
            r_step_cnt   <= '0;
            r_roll_req   <= 1'b0;
            dice_value   <= 3'd0;
            dice_pips    <= PIPS_0;
            rolling      <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_roll_req <= w_btn_rise & w_btn_level;
            done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    rolling <= 1'b0;
                    if (r_roll_req) begin
                        r_state      <= ST_TUMBLE;
                        r_tumble_cnt <= c_tumble_load;
                        r_step_cnt   <= '0;
                        rolling      <= 1'b1;
                    end
                end
                ST_TUMBLE: begin
                    r_tumble_cnt <= r_tumble_cnt - 1'b1;
                    if ((r_step_cnt == '0) && w_face_ok) begin
                        dice_value <= rand_value;
                        dice_pips  <= face_pips(rand_value);
                    end
                    r_step_cnt <= (r_step_cnt == c_step_last) ? '0 : r_step_cnt + 1'b1;
                    if (r_tumble_cnt == '0) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_face_ok) begin
                        dice_value <= rand_value;
                        dice_pips  <= face_pips(rand_value);
                        done       <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    rolling <= 1'b0;
                end
            endcase
        end
    end

endmodule : dice_roller
`default_nettype wire

// File: tb/tb_dice_roller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dice_roller
// Brief    : Directed self-checking bench for dice_roller at default parameters.
// Revision : 1.0
// ============================================================================
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rand_value = 3'd0;
    logic       roll_btn = 1'b0;
    logic [2:0] dice_value;
    logic [6:0] dice_pips;
    logic       rolling;
    logic       done;

    int checks = 0;
    int failures = 0;

    dice_roller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_value (rand_value),
        .roll_btn   (roll_btn),
        .dice_value (dice_value),
        .dice_pips  (dice_pips),
        .rolling    (rolling),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rolling(output int n);
        n = 0;
        while (rolling !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        roll_btn = 1'b0;
        rand_value = 3'd0;
        #20;
        checks++;
        if (dice_value !== 3'd0) begin
            failures++;
            $display("FAIL reset_dice_value: got %0d expected 0", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h00) begin
            failures++;
            $display("FAIL reset_dice_pips: got %h expected 00", dice_pips);
        end
        checks++;
        if (rolling !== 1'b0) begin
            failures++;
            $display("FAIL reset_rolling: got %b expected 0", rolling);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_glitch();
        int hits;
        hits = 0;
        roll_btn = 1'b1;
        step();
        step();
        roll_btn = 1'b0;
        repeat (20) begin
            step();
            if (rolling || done) hits++;
        end
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL glitch_no_roll: got %0d active cycles expected 0", hits);
        end
    endtask

    task automatic test_normal();
        int n;
        int hits;
        rand_value = 3'd5;
        roll_btn = 1'b1;
        // Button first sampled at edge k; rolling must appear right after edge k+7.
        wait_rolling(n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL normal_latency: got %0d steps expected 8", n);
        end
        step();
        step();
        checks++;
        if (dice_value !== 3'd5) begin
            failures++;
            $display("FAIL normal_tumble_face: got %0d expected 5", dice_value);
        end
        roll_btn = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 15) begin
            failures++;
            $display("FAIL normal_done_time: got %0d steps expected 15", n);
        end
        checks++;
        if (dice_value !== 3'd5) begin
            failures++;
            $display("FAIL normal_final_face: got %0d expected 5", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h6B) begin
            failures++;
            $display("FAIL normal_pips: got %h expected 6b", dice_pips);
        end
        checks++;
        if (rolling !== 1'b1) begin
            failures++;
            $display("FAIL normal_rolling_at_done: got %b expected 1", rolling);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL normal_done_pulse_width: got %b expected 0", done);
        end
        checks++;
        if (rolling !== 1'b0) begin
            failures++;
            $display("FAIL normal_rolling_after: got %b expected 0", rolling);
        end
        hits = 0;
        repeat (30) begin
            step();
            if (rolling || done) hits++;
        end
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL normal_idle_quiet: got %0d active cycles expected 0", hits);
        end
    endtask

    task automatic test_invalid();
        int n;
        int dones;
        rand_value = 3'd7;
        roll_btn = 1'b1;
        wait_rolling(n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL invalid_latency: got %0d steps expected 8", n);
        end
        roll_btn = 1'b0;
        dones = 0;
        for (int i = 1; i <= 26; i++) begin
            step();
            if (done) dones++;
            if (i == 5) begin
                checks++;
                if (dice_value !== 3'd5) begin
                    failures++;
                    $display("FAIL invalid_face_held: got %0d expected 5", dice_value);
                end
            end
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL invalid_no_done: got %0d pulses expected 0", dones);
        end
        checks++;
        if (rolling !== 1'b1) begin
            failures++;
            $display("FAIL invalid_still_rolling: got %b expected 1", rolling);
        end
        rand_value = 3'd3;
        step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL invalid_done_on_3: got %b expected 1", done);
        end
        checks++;
        if (dice_value !== 3'd3) begin
            failures++;
            $display("FAIL invalid_face: got %0d expected 3", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h49) begin
            failures++;
            $display("FAIL invalid_pips: got %h expected 49", dice_pips);
        end
        rand_value = 3'd0;
        step();
        checks++;
        if (rolling !== 1'b0) begin
            failures++;
            $display("FAIL invalid_rolling_after: got %b expected 0", rolling);
        end
    endtask

    task automatic test_repress();
        int n;
        int dones;
        int late;
        bit seen;
        dones = 0;
        late = 0;
        seen = 1'b0;
        rand_value = 3'd2;
        roll_btn = 1'b1;
        wait_rolling(n);
        roll_btn = 1'b0;
        repeat (8) begin
            step();
            if (done) dones++;
        end
        // Second press debounces near the end of TUMBLE and must be dropped.
        roll_btn = 1'b1;
        repeat (6) begin
            step();
            if (done) dones++;
        end
        roll_btn = 1'b0;
        repeat (40) begin
            step();
            if (done) begin
                dones++;
                seen = 1'b1;
            end else if (seen && rolling) begin
                late++;
            end
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL repress_one_done: got %0d pulses expected 1", dones);
        end
        checks++;
        if (late !== 0) begin
            failures++;
            $display("FAIL repress_no_second_roll: got %0d rolling cycles expected 0", late);
        end
        checks++;
        if (rolling !== 1'b0) begin
            failures++;
            $display("FAIL repress_rolling_end: got %b expected 0", rolling);
        end
        checks++;
        if (dice_value !== 3'd2) begin
            failures++;
            $display("FAIL repress_face: got %0d expected 2", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h41) begin
            failures++;
            $display("FAIL repress_pips: got %h expected 41", dice_pips);
        end
    endtask

    task automatic test_midreset();
        int n;
        int hits;
        rand_value = 3'd6;
        roll_btn = 1'b1;
        wait_rolling(n);
        roll_btn = 1'b0;
        repeat (5) step();
        checks++;
        if (dice_value !== 3'd6) begin
            failures++;
            $display("FAIL midreset_tumble_face: got %0d expected 6", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h77) begin
            failures++;
            $display("FAIL midreset_tumble_pips: got %h expected 77", dice_pips);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dice_value !== 3'd0) begin
            failures++;
            $display("FAIL midreset_dice_value: got %0d expected 0", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h00) begin
            failures++;
            $display("FAIL midreset_dice_pips: got %h expected 00", dice_pips);
        end
        checks++;
        if (rolling !== 1'b0) begin
            failures++;
            $display("FAIL midreset_rolling: got %b expected 0", rolling);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_done: got %b expected 0", done);
        end
        step();
        rst_n = 1'b1;
        hits = 0;
        repeat (30) begin
            step();
            if (rolling || done) hits++;
        end
        checks++;
        if (hits !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", hits);
        end
        rand_value = 3'd4;
        roll_btn = 1'b1;
        wait_rolling(n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL midreset_relatency: got %0d steps expected 8", n);
        end
        roll_btn = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL midreset_done_time: got %0d steps expected 17", n);
        end
        checks++;
        if (dice_value !== 3'd4) begin
            failures++;
            $display("FAIL midreset_face: got %0d expected 4", dice_value);
        end
        checks++;
        if (dice_pips !== 7'h63) begin
            failures++;
            $display("FAIL midreset_pips: got %h expected 63", dice_pips);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_normal();
        test_invalid();
        test_repress();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dice_roller
`default_nettype wire
